// File: rtl/ysyx22041405_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx22041405_mem_lsu
// Description : MEM-stage load/store unit: one op in, one bus transaction,
//               one write-back result out. MEM_MISALIGN_TRAP_EN selects a
//               trap on misaligned access instead of forced alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx22041405_mem_lsu #(
  parameter int WIDTH  = 32,
  parameter int STRB_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_en,
  input  logic              in_mem_we,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [WIDTH-1:0]  pc_add4,
  input  logic [WIDTH-1:0]  rf_rs2,
  input  logic              mem_addr_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic              out_excp,
  output logic [WIDTH-1:0]  out_badaddr
);

  localparam int c_off_w = $clog2(STRB_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [c_off_w-1:0]  off_q, off_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                excp_q, excp_d;
  logic [WIDTH-1:0]    badaddr_q, badaddr_d;
  logic                misaligned;
`endif

  logic [1:0]          eff_size;
  logic [c_off_w-1:0]  in_off, align_mask, eff_off;
  logic [STRB_W-1:0]   size_mask;
  logic [WIDTH-1:0]    shifted, word_ext, load_ext;

  // A narrow datapath has no doubleword; size 11 collapses to word.
  assign eff_size = (WIDTH == 32 && in_size == 2'b11) ? 2'b10 : in_size;
  assign in_off   = alu_result[c_off_w-1:0];

  always_comb begin
    align_mask = c_off_w'((32'd1 << eff_size) - 32'd1);
    size_mask  = '0;
    case (eff_size)
      2'b00:   size_mask = STRB_W'(1);
      2'b01:   size_mask = STRB_W'(3);
      2'b10:   size_mask = STRB_W'(15);
      default: size_mask = '1;
    endcase
  end

  // Clearing the sub-size offset bits is a no-op for aligned accesses.
  assign eff_off = in_off & ~align_mask;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = |(in_off & align_mask);
`endif

  assign shifted = mem_rdata >> {off_q, 3'b000};

  generate
    if (WIDTH == 64) begin : g_w64
      assign word_ext = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
    end else begin : g_w32
      assign word_ext = shifted;
    end
  endgenerate

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = word_ext;
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rf_wdata_d = rf_wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
    excp_d     = excp_q;
    badaddr_d  = badaddr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          we_d   = in_mem_we;
          size_d = eff_size;
          uns_d  = in_unsigned;
          off_d  = eff_off;
          if (!in_mem_en) begin
            rf_wdata_d = mem_addr_sel ? alu_result : pc_add4;
`ifdef MEM_MISALIGN_TRAP_EN
            excp_d     = 1'b0;
`endif
            state_d    = HOLD;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (misaligned) begin
            rf_wdata_d = '0;
            excp_d     = 1'b1;
            badaddr_d  = alu_result;
            state_d    = HOLD;
          end
`endif
          else begin
            addr_d     = {alu_result[WIDTH-1:c_off_w], eff_off};
            wdata_d    = rf_rs2 << {eff_off, 3'b000};
            wstrb_d    = in_mem_we ? (size_mask << eff_off) : '0;
            rf_wdata_d = '0;
`ifdef MEM_MISALIGN_TRAP_EN
            excp_d     = 1'b0;
`endif
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? HOLD : RESP;
      end
      RESP: begin
        if (mem_rvalid) begin
          rf_wdata_d = load_ext;
          state_d    = HOLD;
        end
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rf_wdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      excp_q     <= 1'b0;
      badaddr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
      excp_q     <= excp_d;
      badaddr_q  <= badaddr_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign out_valid = (state_q == HOLD);
  assign rf_wdata  = rf_wdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign out_excp    = excp_q;
  assign out_badaddr = badaddr_q;
`else
  assign out_excp    = 1'b0;
  assign out_badaddr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx22041405_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx22041405_mem_lsu
// Description : Directed self-checking bench for the MEM-stage LSU, with a
//               32-bit instance and a 64-bit instance for doubleword access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx22041405_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid, in_ready, in_mem_en, in_mem_we, in_unsigned, mem_addr_sel;
  logic [1:0]  in_size;
  logic [31:0] alu_result, pc_add4, rf_rs2;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, out_valid, out_ready, out_excp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_wdata, out_badaddr;
  logic [3:0]  mem_wstrb;

  logic        d_in_valid, d_in_ready, d_in_mem_en, d_in_mem_we, d_in_unsigned, d_mem_addr_sel;
  logic [1:0]  d_in_size;
  logic [63:0] d_alu_result, d_pc_add4, d_rf_rs2;
  logic        d_mem_req, d_mem_we, d_mem_gnt, d_mem_rvalid, d_out_valid, d_out_ready, d_out_excp;
  logic [63:0] d_mem_addr, d_mem_wdata, d_mem_rdata, d_rf_wdata, d_out_badaddr;
  logic [7:0]  d_mem_wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx22041405_mem_lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_size(in_size),
    .in_unsigned(in_unsigned), .alu_result(alu_result), .pc_add4(pc_add4),
    .rf_rs2(rf_rs2), .mem_addr_sel(mem_addr_sel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .rf_wdata(rf_wdata), .out_excp(out_excp), .out_badaddr(out_badaddr)
  );

  ysyx22041405_mem_lsu #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_mem_en(d_in_mem_en), .in_mem_we(d_in_mem_we), .in_size(d_in_size),
    .in_unsigned(d_in_unsigned), .alu_result(d_alu_result), .pc_add4(d_pc_add4),
    .rf_rs2(d_rf_rs2), .mem_addr_sel(d_mem_addr_sel), .mem_req(d_mem_req),
    .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
    .mem_wstrb(d_mem_wstrb), .mem_gnt(d_mem_gnt), .mem_rvalid(d_mem_rvalid),
    .mem_rdata(d_mem_rdata), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .rf_wdata(d_rf_wdata), .out_excp(d_out_excp), .out_badaddr(d_out_badaddr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic en, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [31:0] rs2,
                          input logic sel);
    in_valid     = 1'b1;
    in_mem_en    = en;
    in_mem_we    = we;
    in_size      = sz;
    in_unsigned  = uns;
    alu_result   = alu;
    pc_add4      = pc;
    rf_rs2       = rs2;
    mem_addr_sel = sel;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    tests++;
    if ({in_ready, mem_req, mem_we, out_valid, out_excp} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 10000", {in_ready, mem_req, mem_we, out_valid, out_excp});
    end
    tests++;
    if ({mem_addr, mem_wdata, mem_wstrb, rf_wdata, out_badaddr} !== 132'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, mem_wstrb, rf_wdata, out_badaddr});
    end
    tests++;
    if ({d_in_ready, d_mem_req, d_out_valid, d_mem_wstrb, d_rf_wdata} !== {3'b100, 72'h0}) begin
      fails++;
      $display("FAIL reset_64: got %h want %h", {d_in_ready, d_mem_req, d_out_valid, d_mem_wstrb, d_rf_wdata}, {3'b100, 72'h0});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h1111_0000, 32'h8000_0004, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, mem_req} !== 2'b10) begin
      fails++;
      $display("FAIL pass_latency: got valid/req=%b want 10", {out_valid, mem_req});
    end
    tests++;
    if (rf_wdata !== 32'h8000_0004) begin
      fails++;
      $display("FAIL pass_pc: got %h want 80000004", rf_wdata);
    end
    tick();
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h1111_0000, 32'h8000_0004, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    tests++;
    if (rf_wdata !== 32'h1111_0000) begin
      fails++;
      $display("FAIL pass_alu: got %h want 11110000", rf_wdata);
    end
    tick();
  endtask

  task automatic test_store;
    mem_gnt = 1'b0;
    drive_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h8000_1003, 32'h0, 32'h0000_00AB, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mem_req, mem_we, out_valid, mem_wstrb, mem_addr, mem_wdata} !==
          {3'b110, 4'b1000, 32'h8000_1003, 32'hAB00_0000}) begin
        fails++;
        $display("FAIL store_byte_hold[%0d]: got req/we/valid=%b strb=%b addr=%h wdata=%h want 110 1000 80001003 ab000000",
                 i, {mem_req, mem_we, out_valid}, mem_wstrb, mem_addr, mem_wdata);
      end
      if (i == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    tests++;
    if ({out_valid, mem_req, rf_wdata} !== {2'b10, 32'h0}) begin
      fails++;
      $display("FAIL store_byte_done: got valid/req=%b rf=%h want 10 0", {out_valid, mem_req}, rf_wdata);
    end
    tick();
    // Half store with grant in the first request cycle: two-cycle latency.
    drive_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h8000_1002, 32'h0, 32'h0000_BEEF, 1'b1);
    tick();
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    tests++;
    if ({mem_req, mem_wstrb, mem_wdata} !== {1'b1, 4'b1100, 32'hBEEF_0000}) begin
      fails++;
      $display("FAIL store_half: got req=%b strb=%b wdata=%h want 1 1100 beef0000", mem_req, mem_wstrb, mem_wdata);
    end
    tick();
    mem_gnt = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL store_latency: got out_valid=%b want 1", out_valid);
    end
    tick();
  endtask

  logic [31:0] ld_addr [4] = '{32'h8000_1002, 32'h8000_1002, 32'h8000_1001, 32'h8000_1000};
  logic [1:0]  ld_size [4] = '{2'b01, 2'b01, 2'b00, 2'b10};
  logic        ld_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] ld_data [4] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_F200, 32'hDEAD_BEEF};
  logic [31:0] ld_exp  [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF2, 32'hDEAD_BEEF};

  task automatic test_load;
    for (int k = 0; k < 4; k++) begin
      drive_op(1'b1, 1'b0, ld_size[k], ld_uns[k], ld_addr[k], 32'h0, 32'h0, 1'b1);
      tick();
      in_valid = 1'b0;
      tests++;
      if ({mem_req, mem_we, mem_wstrb, mem_addr} !== {2'b10, 4'b0000, ld_addr[k]}) begin
        fails++;
        $display("FAIL load_req[%0d]: got req/we=%b strb=%b addr=%h want 10 0000 %h",
                 k, {mem_req, mem_we}, mem_wstrb, mem_addr, ld_addr[k]);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = ld_data[k];
      tests++;
      if ({out_valid, mem_req} !== 2'b00) begin
        fails++;
        $display("FAIL load_resp[%0d]: got valid/req=%b want 00", k, {out_valid, mem_req});
      end
      tick();
      mem_rvalid = 1'b0;
      tests++;
      if ({out_valid, rf_wdata} !== {1'b1, ld_exp[k]}) begin
        fails++;
        $display("FAIL load_data[%0d]: got valid=%b rf=%h want 1 %h", k, out_valid, rf_wdata, ld_exp[k]);
      end
      tick();
    end
  endtask

  task automatic test_misaligned;
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_1001, 32'h0, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    tests++;
    if ({mem_req, out_valid, out_excp, out_badaddr, rf_wdata} !== {3'b011, 32'h8000_1001, 32'h0}) begin
      fails++;
      $display("FAIL misalign_trap: got req/valid/excp=%b bad=%h rf=%h want 011 80001001 0",
               {mem_req, out_valid, out_excp}, out_badaddr, rf_wdata);
    end
    tick();
`else
    tests++;
    if ({mem_req, out_excp, mem_addr} !== {2'b10, 32'h8000_1000}) begin
      fails++;
      $display("FAIL misalign_addr: got req/excp=%b addr=%h want 10 80001000", {mem_req, out_excp}, mem_addr);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1122_3344;
    tick();
    mem_rvalid = 1'b0;
    tests++;
    if ({out_valid, out_excp, rf_wdata} !== {2'b10, 32'h1122_3344}) begin
      fails++;
      $display("FAIL misalign_load: got valid/excp=%b rf=%h want 10 11223344", {out_valid, out_excp}, rf_wdata);
    end
    tick();
    drive_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h8000_1003, 32'h0, 32'h0000_CAFE, 1'b1);
    tick();
    in_valid = 1'b0;
    tests++;
    if ({mem_addr, mem_wstrb, mem_wdata} !== {32'h8000_1002, 4'b1100, 32'hCAFE_0000}) begin
      fails++;
      $display("FAIL misalign_store: got addr=%h strb=%b wdata=%h want 80001002 1100 cafe0000",
               mem_addr, mem_wstrb, mem_wdata);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
`endif
  endtask

  task automatic test_hold_stall;
    out_ready = 1'b0;
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
    tick();
    drive_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({out_valid, in_ready, rf_wdata} !== {2'b10, 32'h1234_5678}) begin
        fails++;
        $display("FAIL hold_stable[%0d]: got valid/ready=%b rf=%h want 10 12345678",
                 i, {out_valid, in_ready}, rf_wdata);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL hold_release: got ready/valid=%b want 10", {in_ready, out_valid});
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, rf_wdata} !== {1'b1, 32'hCAFE_F00D}) begin
      fails++;
      $display("FAIL hold_next_op: got valid=%b rf=%h want 1 cafef00d", out_valid, rf_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_1000, 32'h0, 32'h0, 1'b1);
    tick();
    in_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst     = 1'b0;
    tick();
    rst = 1'b1;
    tests++;
    if ({in_ready, out_valid, mem_req, rf_wdata, mem_addr} !== {3'b100, 64'h0}) begin
      fails++;
      $display("FAIL reset_mid: got ready/valid/req=%b rf=%h addr=%h want 100 0 0",
               {in_ready, out_valid, mem_req}, rf_wdata, mem_addr);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA_55AA;
    mem_gnt    = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    tests++;
    if ({in_ready, out_valid, mem_req, rf_wdata} !== {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL late_resp: got ready/valid/req=%b rf=%h want 100 0", {in_ready, out_valid, mem_req}, rf_wdata);
    end
    tick();
  endtask

  logic [63:0] d_addr [2] = '{64'h0000_0000_8000_1008, 64'h0000_0000_8000_1004};
  logic [1:0]  d_size [2] = '{2'b11, 2'b10};
  logic [63:0] d_data [2] = '{64'h8877_6655_4433_2211, 64'h8000_0000_0000_0000};
  logic [63:0] d_exp  [2] = '{64'h8877_6655_4433_2211, 64'hFFFF_FFFF_8000_0000};

  task automatic test_dword64;
    for (int k = 0; k < 2; k++) begin
      d_in_valid   = 1'b1;
      d_in_mem_en  = 1'b1;
      d_in_mem_we  = 1'b0;
      d_in_size    = d_size[k];
      d_alu_result = d_addr[k];
      tick();
      d_in_valid = 1'b0;
      tests++;
      if ({d_mem_req, d_mem_addr} !== {1'b1, d_addr[k]}) begin
        fails++;
        $display("FAIL d64_req[%0d]: got req=%b addr=%h want 1 %h", k, d_mem_req, d_mem_addr, d_addr[k]);
      end
      d_mem_gnt = 1'b1;
      tick();
      d_mem_gnt    = 1'b0;
      d_mem_rvalid = 1'b1;
      d_mem_rdata  = d_data[k];
      tick();
      d_mem_rvalid = 1'b0;
      tests++;
      if ({d_out_valid, d_rf_wdata} !== {1'b1, d_exp[k]}) begin
        fails++;
        $display("FAIL d64_load[%0d]: got valid=%b rf=%h want 1 %h", k, d_out_valid, d_rf_wdata, d_exp[k]);
      end
      tick();
    end
    d_in_valid   = 1'b1;
    d_in_mem_we  = 1'b1;
    d_in_size    = 2'b11;
    d_alu_result = 64'h0000_0000_8000_1008;
    d_rf_rs2     = 64'h0123_4567_89AB_CDEF;
    tick();
    d_in_valid = 1'b0;
    d_mem_gnt  = 1'b1;
    tests++;
    if ({d_mem_we, d_mem_wstrb, d_mem_wdata} !== {1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF}) begin
      fails++;
      $display("FAIL d64_store: got we=%b strb=%h wdata=%h want 1 ff 0123456789abcdef",
               d_mem_we, d_mem_wstrb, d_mem_wdata);
    end
    tick();
    d_mem_gnt = 1'b0;
    tick();
  endtask

  initial begin
    in_valid = 1'b0; in_mem_en = 1'b0; in_mem_we = 1'b0; in_size = 2'b00;
    in_unsigned = 1'b0; alu_result = '0; pc_add4 = '0; rf_rs2 = '0;
    mem_addr_sel = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_mem_en = 1'b0; d_in_mem_we = 1'b0; d_in_size = 2'b00;
    d_in_unsigned = 1'b0; d_alu_result = '0; d_pc_add4 = '0; d_rf_rs2 = '0;
    d_mem_addr_sel = 1'b0; d_mem_gnt = 1'b0; d_mem_rvalid = 1'b0; d_mem_rdata = '0;
    d_out_ready = 1'b1;

    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_misaligned();
    test_hold_stall();
    test_reset_mid();
    test_dword64();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
